rvvi_msg_arbiter: RTL and testbench

Shares the single RVVI message/reporting channel between NREQ independent checkers. Each checker posts info or error records; the block grants them round-robin, buffers one record, and counts errors and infos. When the error count reaches MAX_ERRORS it halts the channel, flushes further requests and raises a sticky `halt` that the bench uses to end simulation. It sits between the per-hart/per-field comparators and the message sink that prints and finishes.

---
 rtl/rvvi_msg_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_rvvi_msg_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_msg_arbiter.sv
// Round-robin arbiter sharing one RVVI message channel between NREQ checkers.
// Buffers one record, counts delivered errors/infos, and halts after MAX_ERRORS errors.
`timescale 1ns/1ps
module rvvi_msg_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned MAX_ERRORS = 5,
  parameter int unsigned CODE_W     = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_error,
  input  logic [NREQ*CODE_W-1:0]       req_code,
  output logic [NREQ-1:0]              req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NREQ)-1:0]      out_src,
  output logic                         out_error,
  output logic [CODE_W-1:0]            out_code,
  output logic [CNT_W-1:0]             err_count,
  output logic [CNT_W-1:0]             info_count,
  output logic                         halt,
  input  logic                         halt_clr
);

  localparam int unsigned SRC_W = $clog2(NREQ);
  localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;
  logic               out_error_q, out_error_d;
  logic [CODE_W-1:0]  out_code_q, out_code_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   info_count_q, info_count_d;
  logic               halt_q, halt_d;

  logic               win_found;
  logic [SRC_W-1:0]   win_idx;
  int unsigned        arb_pos;
  logic [SRC_W-1:0]   arb_sel;
  logic               delivery;
  logic               halt_trig;
  logic               can_accept;
  logic               accept;

  // Round-robin search starting one past the last winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_pos   = 0;
    arb_sel   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      arb_pos = (32'(last_q) + k) % NREQ;
      arb_sel = SRC_W'(arb_pos);
      if (!win_found && req_valid[arb_sel]) begin
        win_found = 1'b1;
        win_idx   = arb_sel;
      end
    end
  end

  // Delivery of the error that reaches the limit blocks any refill that cycle
  always_comb begin
    delivery   = out_valid_q && out_ready;
    halt_trig  = delivery && out_error_q && (MAX_ERRORS != 0) &&
                 ((32'(err_count_q) + 32'd1) == MAX_ERRORS);
    can_accept = !halt_clr && !halt_trig &&
                 ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && delivery));
    accept     = can_accept && win_found;
    req_ready  = '0;
    if (state_q == ST_HALT) begin
      req_ready = '1;
    end else if (accept) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    end
  end

  // Next-state and buffer/counter updates
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    out_valid_d  = out_valid_q;
    out_src_d    = out_src_q;
    out_error_d  = out_error_q;
    out_code_d   = out_code_q;
    err_count_d  = err_count_q;
    info_count_d = info_count_q;
    halt_d       = halt_q;

    if (halt_clr) begin
      state_d      = ST_EMPTY;
      last_d       = LAST_RST;
      out_valid_d  = 1'b0;
      out_src_d    = '0;
      out_error_d  = 1'b0;
      out_code_d   = '0;
      err_count_d  = '0;
      info_count_d = '0;
      halt_d       = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_FULL;
            out_valid_d = 1'b1;
          end
        end
        ST_FULL: begin
          if (delivery) begin
            if (out_error_q) begin
              if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
            end else begin
              if (info_count_q != CNT_MAX) info_count_d = info_count_q + CNT_W'(1);
            end
            if (halt_trig) begin
              state_d     = ST_HALT;
              out_valid_d = 1'b0;
              halt_d      = 1'b1;
            end else if (!accept) begin
              state_d     = ST_EMPTY;
              out_valid_d = 1'b0;
            end
          end
        end
        ST_HALT: begin
          out_valid_d = 1'b0;
          halt_d      = 1'b1;
        end
        default: begin
          state_d     = ST_EMPTY;
          out_valid_d = 1'b0;
        end
      endcase

      if (accept) begin
        last_d      = win_idx;
        out_src_d   = win_idx;
        out_error_d = req_error[win_idx];
        out_code_d  = req_code[32'(win_idx)*CODE_W +: CODE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      last_q       <= LAST_RST;
      out_valid_q  <= 1'b0;
      out_src_q    <= '0;
      out_error_q  <= 1'b0;
      out_code_q   <= '0;
      err_count_q  <= '0;
      info_count_q <= '0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      out_valid_q  <= out_valid_d;
      out_src_q    <= out_src_d;
      out_error_q  <= out_error_d;
      out_code_q   <= out_code_d;
      err_count_q  <= err_count_d;
      info_count_q <= info_count_d;
      halt_q       <= halt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_src    = out_src_q;
  assign out_error  = out_error_q;
  assign out_code   = out_code_q;
  assign err_count  = err_count_q;
  assign info_count = info_count_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_rvvi_msg_arbiter.sv
// Directed bench for rvvi_msg_arbiter: single post, round-robin fairness,
// back-pressure, error halt, halt_clr and reset while a record is buffered.
`timescale 1ns/1ps
module tb_rvvi_msg_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned CODE_W = 16;
  localparam int unsigned CNT_W  = 16;

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_error;
  logic [NREQ*CODE_W-1:0] req_code;
  logic [NREQ-1:0]        req_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_src;
  logic                   out_error;
  logic [CODE_W-1:0]      out_code;
  logic [CNT_W-1:0]       err_count;
  logic [CNT_W-1:0]       info_count;
  logic                   halt;
  logic                   halt_clr;

  int checks;
  int errors;

  rvvi_msg_arbiter #(
    .NREQ(NREQ), .MAX_ERRORS(5), .CODE_W(CODE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_error(req_error), .req_code(req_code),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_error(out_error), .out_code(out_code),
    .err_count(err_count), .info_count(info_count),
    .halt(halt), .halt_clr(halt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_error = '0;
    req_code  = '0;
    out_ready = 1'b0;
    halt_clr  = 1'b0;

    // reset state
    cyc();
    cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_info_count", 32'(info_count), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    cyc();

    // single info from requester 2
    req_valid = 4'b0100;
    req_code[2*CODE_W +: CODE_W] = 16'h00AB;
    out_ready = 1'b1;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = '0;
    #1;
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_src", 32'(out_src), 32'd2);
    chk("single_out_code", 32'(out_code), 32'h00AB);
    chk("single_out_error", 32'(out_error), 32'd0);
    cyc();
    chk("single_info_count", 32'(info_count), 32'd1);
    chk("single_err_count", 32'(err_count), 32'd0);
    chk("single_drained", 32'(out_valid), 32'd0);

    // clear counters and pointer, then all four requesters continuously
    halt_clr = 1'b1;
    cyc();
    halt_clr = 1'b0;
    chk("clr_info_count", 32'(info_count), 32'd0);
    for (int i = 0; i < 4; i++) req_code[i*CODE_W +: CODE_W] = CODE_W'(16'h0010 + i);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_req_ready", 32'(req_ready), 32'(1) << (k % 4));
      cyc();
      chk("rr_out_src", 32'(out_src), 32'(k % 4));
      chk("rr_out_code", 32'(out_code), 32'h10 + 32'(k % 4));
      chk("rr_info_count", 32'(info_count), 32'(k));
    end
    req_valid = '0;
    #1;
    chk("rr_idle_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("rr_info_total", 32'(info_count), 32'd8);
    chk("rr_idle_valid", 32'(out_valid), 32'd0);

    // back-pressure: record from 1 held while requester 3 waits
    req_code[1*CODE_W +: CODE_W] = 16'h00C1;
    req_code[3*CODE_W +: CODE_W] = 16'h00C3;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_src", 32'(out_src), 32'd1);
      chk("bp_out_code", 32'(out_code), 32'h00C1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_info_count", 32'(info_count), 32'd8);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_refill_ready", 32'(req_ready), 32'h8);
    cyc();
    chk("bp_refill_src", 32'(out_src), 32'd3);
    chk("bp_refill_code", 32'(out_code), 32'h00C3);
    chk("bp_release_count", 32'(info_count), 32'd9);
    req_valid = '0;
    cyc();
    chk("bp_final_count", 32'(info_count), 32'd10);
    chk("bp_final_valid", 32'(out_valid), 32'd0);

    // requesters 1 and 3 post errors until halt
    req_error = 4'b1010;
    req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("err_req_ready", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      cyc();
      chk("err_out_src", 32'(out_src), (k % 2 == 0) ? 32'd1 : 32'd3);
      chk("err_out_error", 32'(out_error), 32'd1);
      chk("err_count_run", 32'(err_count), 32'(k));
    end
    #1;
    chk("halt_edge_ready", 32'(req_ready), 32'd0);
    chk("halt_edge_halt", 32'(halt), 32'd0);
    cyc();
    chk("halt_set", 32'(halt), 32'd1);
    chk("halt_err_count", 32'(err_count), 32'd5);
    chk("halt_out_valid", 32'(out_valid), 32'd0);
    chk("halt_req_ready", 32'(req_ready), 32'hF);
    cyc();
    cyc();
    chk("halt_frozen_err", 32'(err_count), 32'd5);
    chk("halt_frozen_info", 32'(info_count), 32'd10);
    chk("halt_frozen_valid", 32'(out_valid), 32'd0);
    chk("halt_sticky", 32'(halt), 32'd1);

    // halt_clr returns to EMPTY with requester 0 first
    req_valid = '0;
    halt_clr  = 1'b1;
    cyc();
    halt_clr  = 1'b0;
    chk("hclr_halt", 32'(halt), 32'd0);
    chk("hclr_err_count", 32'(err_count), 32'd0);
    chk("hclr_info_count", 32'(info_count), 32'd0);
    chk("hclr_out_valid", 32'(out_valid), 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("hclr_grant0", 32'(req_ready), 32'h1);
    cyc();
    chk("hclr_out_src", 32'(out_src), 32'd0);
    chk("hclr_out_code", 32'(out_code), 32'h0010);
    chk("hclr_buffered", 32'(out_valid), 32'd1);

    // asynchronous reset while FULL drops the record
    req_valid = '0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_src", 32'(out_src), 32'd0);
    chk("arst_out_code", 32'(out_code), 32'd0);
    chk("arst_out_error", 32'(out_error), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_info_count", 32'(info_count), 32'd0);
    chk("arst_halt", 32'(halt), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    cyc();
    reset = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("arst_no_replay", 32'(out_valid), 32'd0);
    cyc();
    chk("arst_no_count", 32'(info_count) + 32'(err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
